// File: rtl/fm_pkg.sv
// Shared definitions for the frequency-multiplier sequencer: default widths,
// the sequencer state encoding and the autotrack deviation threshold.
package fm_pkg;

    localparam int FM_CNT_W       = 16;
    localparam int FM_MULT_W      = 4;
    localparam int FM_STATE_W     = 3;
    // A re-measured period is accepted once it deviates by more than period/8.
    localparam int FM_TRACK_SHIFT = 3;

    typedef enum logic [FM_STATE_W-1:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SYNC    = 3'd2,
        MEASURE = 3'd3,
        DIVIDE  = 3'd4,
        RUN     = 3'd5,
        ERR     = 3'd6
    } fm_state_t;

endpackage

// File: rtl/fm_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// done pulses for one cycle CNT_W+1 cycles after start; clr abandons a
// division in flight without ever raising done.
module fm_divider
    import fm_pkg::*;
#(
    parameter int CNT_W  = FM_CNT_W,
    parameter int MULT_W = FM_MULT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              start,
    input  logic [CNT_W-1:0]  dividend,
    input  logic [MULT_W-1:0] divisor,
    output logic              done,
    output logic [CNT_W-1:0]  quotient
);

    localparam int STEP_W = $clog2(CNT_W + 1);

    logic [MULT_W-1:0] rem;
    logic [MULT_W-1:0] dsor;
    logic [CNT_W-1:0]  q;
    logic [STEP_W-1:0] steps;
    logic              running;
    logic [MULT_W:0]   trial;
    logic              fits;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign trial    = {rem, q[CNT_W-1]};
    assign fits     = trial >= {1'b0, dsor};
    assign quotient = q;

    // Load on start, then CNT_W shift/subtract steps, then one done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            dsor    <= '0;
            q       <= '0;
            steps   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                running <= 1'b0;
                steps   <= '0;
            end else if (start) begin
                rem     <= '0;
                q       <= dividend;
                dsor    <= divisor;
                steps   <= STEP_W'(CNT_W);
                running <= 1'b1;
            end else if (running) begin
                if (steps != '0) begin
                    q     <= {q[CNT_W-2:0], fits};
                    rem   <= fits ? MULT_W'(trial - {1'b0, dsor}) : trial[MULT_W-1:0];
                    steps <= steps - 1'b1;
                end else begin
                    done    <= 1'b1;
                    running <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fm_sequencer.sv
// Frequency-multiplier sequencer: measures the sip period, divides it by N
// and emits N evenly spaced fout pulses per period, re-phased on every rise.
// Optional build macro FM_SEQ_AUTOTRACK_EN: keep measuring in RUN and
// re-divide when the period drifts by more than period/8.
module fm_sequencer
    import fm_pkg::*;
#(
    parameter int CNT_W  = FM_CNT_W,
    parameter int MULT_W = FM_MULT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sip,
    input  logic              adjust,
    input  logic [MULT_W-1:0] mult,
    output logic              fout,
    output logic              valid,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  quot
);

    fm_state_t         state;
    fm_state_t         state_next;
    logic              sip_d;
    logic              rise;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  tick;
    logic [MULT_W-1:0] n_lat;
    logic [MULT_W-1:0] pcnt;
    logic [MULT_W-1:0] mult_eff;
    logic              cnt_full;
    logic              cnt_run;
    logic              div_start;
    logic              div_done;
    logic [CNT_W-1:0]  div_q;
    logic              quot_low;

    assign rise     = sip & ~sip_d;
    assign mult_eff = (mult == '0) ? MULT_W'(1) : mult;
    assign cnt_full = &cnt;
    assign quot_low = div_q < CNT_W'(2);

`ifdef FM_SEQ_AUTOTRACK_EN
    logic [CNT_W-1:0] dev;
    logic             retrack;

    assign dev     = (cnt > period) ? (cnt - period) : (period - cnt);
    assign retrack = dev > (period >> FM_TRACK_SHIFT);
    assign cnt_run = state inside {SYNC, MEASURE, DIVIDE, RUN};
`else
    assign cnt_run = state inside {SYNC, MEASURE};
`endif

    fm_divider #(
        .CNT_W  (CNT_W),
        .MULT_W (MULT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .clr      (adjust),
        .start    (div_start),
        .dividend (cnt),
        .divisor  (n_lat),
        .done     (div_done),
        .quotient (div_q)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, divider start and status flags; adjust has top priority.
    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        valid      = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: if (adjust) state_next = ARM;
            ARM:  if (!adjust) state_next = SYNC;
            SYNC: begin
                busy = 1'b1;
                if (adjust)    state_next = ARM;
                else if (rise) state_next = MEASURE;
            end
            MEASURE: begin
                busy = 1'b1;
                if (adjust) begin
                    state_next = ARM;
                end else if (rise) begin
                    div_start  = 1'b1;
                    state_next = DIVIDE;
                end else if (cnt_full) begin
                    state_next = ERR;
                end
            end
            DIVIDE: begin
                busy = 1'b1;
                if (adjust)        state_next = ARM;
                else if (div_done) state_next = quot_low ? ERR : RUN;
            end
            RUN: begin
                valid = 1'b1;
                if (adjust) state_next = ARM;
`ifdef FM_SEQ_AUTOTRACK_EN
                else if (div_done && quot_low) state_next = ERR;
                else if (rise)                 div_start  = retrack;
                else if (cnt_full)             state_next = ERR;
`endif
            end
            ERR: begin
                err = 1'b1;
                if (adjust) state_next = ARM;
            end
            default: state_next = IDLE;
        endcase
    end

    // Period counter, latched factor, results and the fout pulse generator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sip_d  <= 1'b0;
            fout   <= 1'b0;
            period <= '0;
            quot   <= '0;
            cnt    <= '0;
            tick   <= '0;
            n_lat  <= MULT_W'(1);
            pcnt   <= '0;
        end else begin
            sip_d <= sip;
            fout  <= 1'b0;

            if (cnt_run) begin
                if (rise)           cnt <= CNT_W'(1);
                else if (!cnt_full) cnt <= cnt + 1'b1;
            end

            if (div_start) period <= cnt;

            if (!adjust && div_done && (state == DIVIDE || state == RUN))
                quot <= div_q;

            // pcnt starts at N so nothing fires in RUN before the first rise.
            if (state == ARM && !adjust) begin
                n_lat <= mult_eff;
                pcnt  <= mult_eff;
            end

            if (state == RUN && state_next == RUN) begin
                if (rise) begin
                    fout <= 1'b1;
                    tick <= quot - 1'b1;
                    pcnt <= MULT_W'(1);
                end else if (pcnt < n_lat) begin
                    if (tick == '0) begin
                        fout <= 1'b1;
                        pcnt <= pcnt + 1'b1;
                        tick <= quot - 1'b1;
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fm_sequencer.sv
// Bench for fm_sequencer with an 8-bit period counter. Expected fout is
// derived from rise times: pulses at rise + k*quot for k < N, cut off by the
// next rise.
module tb_fm_sequencer;

    localparam int CNT_W  = 8;
    localparam int MULT_W = 4;

    logic              clk;
    logic              rst;
    logic              sip;
    logic              adjust;
    logic [MULT_W-1:0] mult;
    logic              fout;
    logic              valid;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  quot;

    fm_sequencer #(.CNT_W(CNT_W), .MULT_W(MULT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sip    (sip),
        .adjust (adjust),
        .mult   (mult),
        .fout   (fout),
        .valid  (valid),
        .busy   (busy),
        .err    (err),
        .period (period),
        .quot   (quot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [MULT_W-1:0] mult;
        int                p;
        int                exp_period;
        int                exp_quot;
        bit                exp_err;
    } vec_t;

    int vectors;
    int miscompares;
    int edge_n;
    int last_rise;
    int run_start;
    bit sip_en;
    bit jitter;
    int since;
    int gap;
    int base;
    int gap_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // One clock: drive sip from the gap schedule, step past the edge, track rises.
    task automatic cyc();
        sip = sip_en && (since == 0);
        @(posedge clk);
        #1;
        edge_n++;
        if (sip) begin
            last_rise = edge_n;
            if (gap_q.size() > 0) gap = gap_q.pop_front();
            else if (jitter)      gap = int'($urandom_range(2, 2 * base));
            else                  gap = base;
        end
        since = since + 1;
        if (since >= gap) since = 0;
    endtask

    task automatic calibrate(input logic [MULT_W-1:0] m, input int p);
        sip_en = 1'b1;
        jitter = 1'b0;
        base   = p;
        gap    = p;
        since  = 1;
        mult   = m;
        adjust = 1'b1;
        cyc();
        adjust = 1'b0;
        cyc();
    endtask

    task automatic wait_cal();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            cyc();
            if (valid || err) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL cal_timeout: got no valid/err expected one within 1200 cycles");
        end
        run_start = edge_n;
    endtask

    task automatic run_check(input int n, input int q, input int cycles);
        int  d;
        bit  exp_f;
        for (int i = 0; i < cycles; i++) begin
            cyc();
            d     = edge_n - last_rise;
            exp_f = (last_rise > run_start) && (d % q == 0) && (d / q < n);
            chk("fout", fout, exp_f);
        end
        chk("run_valid", valid, 1);
    endtask

    vec_t tbl[8];

    initial begin
        int n;
        int p;
        int nf;
        vectors     = 0;
        miscompares = 0;
        edge_n      = 0;
        last_rise   = -1;
        run_start   = 0;
        sip_en      = 1'b0;
        jitter      = 1'b0;
        since       = 1;
        gap         = 2;
        base        = 2;
        rst         = 1'b1;
        sip         = 1'b0;
        adjust      = 1'b0;
        mult        = '0;

        tbl[0] = '{4'd4,  40,  40,  10, 1'b0};
        tbl[1] = '{4'd0,  20,  20,  20, 1'b0};
        tbl[2] = '{4'd15, 20,  20,  1,  1'b1};
        tbl[3] = '{4'd3,  100, 100, 33, 1'b0};
        tbl[4] = '{4'd1,  2,   2,   2,  1'b0};
        tbl[5] = '{4'd2,  3,   3,   1,  1'b1};
        tbl[6] = '{4'd7,  200, 200, 28, 1'b0};
        tbl[7] = '{4'd15, 255, 255, 17, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fout", fout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_period", period, 0);
        chk("rst_quot", quot, 0);
        rst = 1'b0;
        cyc();
        chk("idle_busy", busy, 0);

        foreach (tbl[i]) begin
            calibrate(tbl[i].mult, tbl[i].p);
            wait_cal();
            chk("cal_period", period, tbl[i].exp_period);
            chk("cal_quot", quot, tbl[i].exp_quot);
            chk("cal_err", err, tbl[i].exp_err);
            chk("cal_valid", valid, !tbl[i].exp_err);
            n = (tbl[i].mult == 0) ? 1 : int'(tbl[i].mult);
            if (!tbl[i].exp_err) begin
                run_check(n, tbl[i].exp_quot, 3 * tbl[i].p + 4);
            end else begin
                nf = 0;
                for (int k = 0; k < 2 * tbl[i].p; k++) begin
                    cyc();
                    nf += int'(fout);
                end
                chk("err_nofout", nf, 0);
                chk("err_hold", err, 1);
                adjust = 1'b1;
                cyc();
                adjust = 1'b0;
                chk("err_leave", err, 0);
                chk("err_arm_busy", busy, 0);
            end
        end

        // Adjust while dividing: old quot (17) must survive, no late load.
        calibrate(4'd4, 40);
        for (int i = 0; i < 300; i++) begin
            if (period == 8'd40) break;
            cyc();
        end
        chk("div_period", period, 40);
        chk("div_busy", busy, 1);
        adjust = 1'b1;
        cyc();
        chk("div_abort_busy", busy, 0);
        chk("div_abort_valid", valid, 0);
        chk("div_abort_quot", quot, 17);
        adjust = 1'b0;
        sip_en = 1'b0;
        repeat (20) cyc();
        chk("div_no_stale", quot, 17);
        chk("div_sync_busy", busy, 1);

        // Stall: single rise in SYNC, counter saturates at 255 then ERR.
        sip_en = 1'b0;
        mult   = 4'd4;
        adjust = 1'b1;
        cyc();
        adjust = 1'b0;
        cyc();
        sip_en = 1'b1;
        since  = 0;
        base   = 1000;
        cyc();
        sip_en = 1'b0;
        repeat (254) cyc();
        chk("stall_pre_err", err, 0);
        cyc();
        chk("stall_err", err, 1);
        chk("stall_busy", busy, 0);
        chk("stall_period_hold", period, 40);

        // Randomized factor and period, then irregular rises where allowed.
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 15));
            p = int'($urandom_range(2 * n, 255));
            calibrate(MULT_W'(n), p);
            wait_cal();
            chk("rnd_period", period, p);
            chk("rnd_quot", quot, p / n);
`ifndef FM_SEQ_AUTOTRACK_EN
            jitter = 1'b1;
`endif
            run_check(n, p / n, 4 * p);
            jitter = 1'b0;
        end

`ifndef FM_SEQ_AUTOTRACK_EN
        // Early rise at 25, rise coinciding with tick expiry at 30.
        calibrate(4'd4, 40);
        wait_cal();
        gap_q.push_back(25);
        gap_q.push_back(30);
        gap_q.push_back(40);
        run_check(4, 10, 250);
        chk("early_period_frozen", period, 40);
`else
        // Period change 40 -> 60 retunes without dropping valid.
        calibrate(4'd4, 40);
        wait_cal();
        run_check(4, 10, 100);
        base = 60;
        nf   = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (!valid) nf++;
            if (period == 8'd60 && quot == 8'd15) break;
        end
        chk("track_period", period, 60);
        chk("track_quot", quot, 15);
        chk("track_valid_drops", nf, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fm_sequencer.md
Name: fm_sequencer

Overview:
Sequencer for the frequency-multiplier datapath. It measures the clk-cycle period of the input pulse stream sip and divides that period by a multiplication factor N. It then emits N evenly spaced one-cycle pulses on fout per input period, re-phased at every sip rising edge. An adjust request restarts calibration; valid reports that fout is tracking.

Parameters:
CNT_W, 16, width of period counter, measured period and quotient
MULT_W, 4, width of multiplication factor N

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
sip  input  1  input pulse stream, already synchronous to clk
adjust  input  1  recalibration request, level
mult  input  MULT_W  factor N, sampled on entry to SYNC
fout  output  1  multiplied pulse train, one-cycle pulses
valid  output  1  high while in RUN
busy  output  1  high in SYNC, MEASURE, DIVIDE
err  output  1  high in ERR
period  output  CNT_W  last measured period in clk cycles
quot  output  CNT_W  period / N

Behaviour:
- Reset (asynchronous, active-high; clock is clk): state IDLE; fout, valid, busy and err are 0; period and quot are 0; sip_d is 0.
- Edge detect: sip_d is a one-cycle register of sip; rise = sip & ~sip_d.
- IDLE: adjust=1 -> ARM.
- ARM: wait for adjust=0 -> SYNC. On that transition, latch N = mult, with mult=0 treated as 1.
- SYNC: on rise, set cnt<=1 and go to MEASURE.
- MEASURE:
  - No rise: cnt<=cnt+1.
  - Rise: period<=cnt, start the divider, go to DIVIDE.
  - cnt reaches all-ones with no rise: go to ERR.
- DIVIDE: wait for divider done (CNT_W+1 cycles after start). Load quot, then:
  - quot<2 -> ERR;
  - otherwise -> RUN.
- RUN:
  - valid=1.
  - On rise: fout=1 in the next cycle (pulse 0), tick<=quot-1, pcnt<=1.
  - While pcnt<N: tick decrements each cycle; when tick reaches 0, pulse fout for one cycle, increment pcnt, reload tick.
  - Once pcnt==N: no further pulses until the next rise.
  - A rise before N pulses are emitted drops the remaining pulses and re-phases immediately.
  - Before the first rise in RUN, fout stays 0.
- ERR: err=1, all other outputs hold, no fout pulses. Only adjust leaves ERR.
- adjust=1 in SYNC, MEASURE, DIVIDE, RUN or ERR:
  - next state is ARM; valid, busy and err are 0 from the next cycle;
  - an in-flight division is abandoned (divider is cleared);
  - period and quot hold their old values until overwritten.
- Simultaneous adjust and rise: adjust wins.
- Simultaneous rise and tick expiry in RUN: the rise wins; exactly one fout pulse is emitted.
- Arithmetic is unsigned; no truncation of period. quot = floor(period/N), and the remainder is discarded, so the last gap per period is longer.

Optional Feature:
FM_SEQ_AUTOTRACK_EN
- Defined: RUN keeps counting between rises. On each rise, if |cnt - period| > (period>>3), set period<=cnt and re-run DIVIDE with valid held at 1. fout holds its current quot until the new quot loads. Counter saturation in RUN -> ERR.
- Undefined: period and quot stay frozen in RUN until adjust.

Decomposition:
- Package fm_pkg: state enum (IDLE, ARM, SYNC, MEASURE, DIVIDE, RUN, ERR) as 3-bit localparams; default CNT_W/MULT_W constants; autotrack threshold shift (3).
- Sub-module fm_divider:
  - sequential restoring divider, CNT_W-bit dividend and MULT_W-bit divisor;
  - ports clk, rst, clr, start, dividend, divisor, done, quotient;
  - one bit per cycle, done pulses CNT_W+1 cycles after start.

Test Plan:
- Calibrate: adjust pulse, mult=4, sip rises every 40 cycles -> period=40, quot=10, valid=1. fout pulses at rise+1, +11, +21, +31; exactly 4 per period.
- mult=0 with sip period 20 -> treated as N=1: quot=20, one fout pulse per rise at rise+1.
- Too fast: mult=15, sip period 20 -> quot=1 -> err=1, valid=0, no fout. A later adjust returns to ARM with err=0.
- Stall: no second sip rise in MEASURE with CNT_W=8 -> ERR after cnt reaches 255.
- Early rise: mult=4, quot=10, next sip rise 25 cycles after the previous one -> only pulses at +1, +11, +21, then re-phase at the new rise+1.
- Mid-operation: adjust during DIVIDE -> ARM next cycle, busy=0, and no stale quot load. With FM_SEQ_AUTOTRACK_EN, a sip period change 40->60 in RUN -> period=60, quot=15, valid stays 1.
